// File: rtl/key_conditioner.sv
// Pushbutton/switch input conditioning: synchronize, debounce and edge-detect
// the active-low KEY pins; synchronize the slide switches without debounce.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_WIDTH        = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] key_n_in,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic [NUM_KEYS-1:0] key_n_out,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [SW_WIDTH-1:0] sw_out
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [NUM_KEYS-1:0]         key_s1_q, key_s1_d;
  logic [NUM_KEYS-1:0]         key_s2_q, key_s2_d;
  logic [NUM_KEYS-1:0]         stable_q, stable_d;
  logic [NUM_KEYS-1:0]         press_q, press_d;
  logic [NUM_KEYS-1:0]         release_q, release_d;
  logic [NUM_KEYS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [SW_WIDTH-1:0]         sw_s1_q, sw_s1_d;
  logic [SW_WIDTH-1:0]         sw_s2_q, sw_s2_d;

  // Next-state logic for synchronizers, debounce counters and edge pulses.
  always_comb begin
    key_s1_d  = key_n_in;
    key_s2_d  = key_s1_q;
    sw_s1_d   = sw_in;
    sw_s2_d   = sw_s1_q;
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_s2_q[i] == stable_q[i]) begin
        // Any return to the accepted level, including a bounce, restarts the count.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i]  = key_s2_q[i];
        cnt_d[i]     = '0;
        press_d[i]   = ~key_s2_q[i];
        release_d[i] = key_s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // State registers; keys reset to released, switches to zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_s1_q  <= '1;
      key_s2_q  <= '1;
      stable_q  <= '1;
      press_q   <= '0;
      release_q <= '0;
      cnt_q     <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
    end else begin
      key_s1_q  <= key_s1_d;
      key_s2_q  <= key_s2_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
      sw_s1_q   <= sw_s1_d;
      sw_s2_q   <= sw_s2_d;
    end
  end

  assign key_n_out     = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign sw_out        = sw_s2_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, NUM_KEYS=4.
module tb_key_conditioner;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] key_n_in;
  logic [7:0] sw_in;
  logic [3:0] key_n_out;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [7:0] sw_out;

  int n_asserts = 0;
  int n_fail    = 0;

  key_conditioner #(
    .NUM_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .SW_WIDTH(8)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .key_n_in(key_n_in),
    .sw_in(sw_in),
    .key_n_out(key_n_out),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .sw_out(sw_out)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all key outputs after the current edge.
  task automatic chk_keys(input string tag, input logic [3:0] k, input logic [3:0] p, input logic [3:0] r);
    chk({tag, ".key_n_out"}, {28'd0, key_n_out}, {28'd0, k});
    chk({tag, ".press"}, {28'd0, press_pulse}, {28'd0, p});
    chk({tag, ".release"}, {28'd0, release_pulse}, {28'd0, r});
  endtask

  // Advance n edges expecting no key output change and no pulses.
  task automatic hold(input string tag, input int n, input logic [3:0] k);
    for (int i = 0; i < n; i++) begin
      step();
      chk_keys(tag, k, 4'b0000, 4'b0000);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    key_n_in = 4'b0101;
    sw_in    = 8'hFF;
    #1;
    repeat (3) step();
    chk_keys("reset", 4'b1111, 4'b0000, 4'b0000);
    chk("reset.sw_out", {24'd0, sw_out}, 32'h0000_0000);

    key_n_in = 4'b1111;
    sw_in    = 8'h00;
    Reset    = 1'b0;
    hold("idle", 4, 4'b1111);

    // Clean press on key 3: accepted on edge 6.
    key_n_in = 4'b0111;
    hold("press3", 5, 4'b1111);
    step();
    chk_keys("press3.e6", 4'b0111, 4'b1000, 4'b0000);
    step();
    chk_keys("press3.e7", 4'b0111, 4'b0000, 4'b0000);

    // Bounce on key 2: 3 low, 1 high, then held low.
    key_n_in = 4'b0011;
    hold("bounce.low", 3, 4'b0111);
    key_n_in = 4'b0111;
    hold("bounce.high", 1, 4'b0111);
    key_n_in = 4'b0011;
    hold("bounce.final", 5, 4'b0111);
    step();
    chk_keys("bounce.e6", 4'b0011, 4'b0100, 4'b0000);
    step();
    chk_keys("bounce.e7", 4'b0011, 4'b0000, 4'b0000);

    // Press key 0 as well.
    key_n_in = 4'b0010;
    hold("press0", 5, 4'b0011);
    step();
    chk_keys("press0.e6", 4'b0010, 4'b0001, 4'b0000);

    // Release key 3 alone.
    key_n_in = 4'b1010;
    hold("rel3", 5, 4'b0010);
    step();
    chk_keys("rel3.e6", 4'b1010, 4'b0000, 4'b1000);

    // Release keys 0 and 2 together.
    key_n_in = 4'b1111;
    hold("rel02", 5, 4'b1010);
    step();
    chk_keys("rel02.e6", 4'b1111, 4'b0000, 4'b0101);
    step();
    chk_keys("rel02.e7", 4'b1111, 4'b0000, 4'b0000);

    // Switch path: two-edge latency.
    sw_in = 8'hA5;
    step();
    chk("sw.e1", {24'd0, sw_out}, 32'h0000_0000);
    step();
    chk("sw.e2", {24'd0, sw_out}, 32'h0000_00A5);

    // Reset in the middle of a key 3 press, key held low throughout.
    key_n_in = 4'b0111;
    hold("rstmid.pre", 3, 4'b1111);
    Reset = 1'b1;
    #1;
    chk_keys("rstmid.async", 4'b1111, 4'b0000, 4'b0000);
    chk("rstmid.sw", {24'd0, sw_out}, 32'h0000_0000);
    hold("rstmid.in", 2, 4'b1111);
    step();
    Reset = 1'b0;
    hold("rstmid.post", 5, 4'b1111);
    step();
    chk_keys("rstmid.e6", 4'b0111, 4'b1000, 4'b0000);
    chk("rstmid.sw_after", {24'd0, sw_out}, 32'h0000_00A5);
    step();
    chk_keys("rstmid.e7", 4'b0111, 4'b0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
